// File: rtl/render_pkg.sv
// Shared types for the render scheduler.
//   TRI_WIDTH     : default width of one packed triangle word
//   triangle_t    : one packed triangle word
//   sched_state_t : frame sequencer states
package render_pkg;

  localparam int TRI_WIDTH = 128;

  typedef logic [TRI_WIDTH-1:0] triangle_t;

  typedef enum logic [2:0] {
    IDLE,
    RRST,
    LOAD,
    START,
    RENDERING
  } sched_state_t;

endpackage

// File: rtl/tri_fetch_pipe.sv
// Triangle fetch pipe: walks a synchronous triangle RAM from address 0 to
// n-1, one address per cycle, and re-times the returning data into a
// registered triangle output with a one-cycle valid strobe.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   start     : one-cycle pulse; the first address is issued on the next cycle
//   n         : number of triangles to fetch (held stable while fetching, >0)
//   addr      : RAM read address (holds its last value when not fetching)
//   tri_data  : RAM read data, READ_LATENCY cycles after addr
//   triangle  : registered triangle word
//   valid     : high for the cycle triangle carries a new word
//   drained   : no more issues pending; the last word is being captured
module tri_fetch_pipe
  import render_pkg::*;
#(
  parameter int TRI_WIDTH     = 128,
  parameter int MAX_TRIANGLES = 64,
  parameter int READ_LATENCY  = 2,
  localparam int ADDR_W = $clog2(MAX_TRIANGLES),
  localparam int CNT_W  = $clog2(MAX_TRIANGLES + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CNT_W-1:0]     n,
  output logic [ADDR_W-1:0]    addr,
  input  logic [TRI_WIDTH-1:0] tri_data,
  output logic [TRI_WIDTH-1:0] triangle,
  output logic                 valid,
  output logic                 drained
);

  // Every stage except the last; once these are empty the final word is in
  // the last stage and is captured on this edge.
  localparam int unsigned LOWER_MASK_I = (1 << (READ_LATENCY - 1)) - 1;

  if (READ_LATENCY < 1) begin : g_bad_latency
    $error("READ_LATENCY must be at least 1");
  end

  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [CNT_W-1:0]        issued_q, issued_d;
  logic                    issue_q, issue_d;
  logic [READ_LATENCY-1:0] pipe_q, pipe_d;
  logic [TRI_WIDTH-1:0]    triangle_q, triangle_d;
  logic                    valid_q, valid_d;

  // issue_q marks that the address currently on addr is a real read.
  always_comb begin
    addr_d   = addr_q;
    issued_d = issued_q;
    issue_d  = 1'b0;
    if (start) begin
      addr_d   = '0;
      issued_d = CNT_W'(1);
      issue_d  = 1'b1;
    end else if (issue_q && (issued_q < n)) begin
      addr_d   = addr_q + ADDR_W'(1);
      issued_d = issued_q + CNT_W'(1);
      issue_d  = 1'b1;
    end
  end

  // Valid shift register tracking each read through the RAM latency.
  assign pipe_d[0] = issue_q;
  for (genvar gi = 1; gi < READ_LATENCY; gi++) begin : g_pipe
    assign pipe_d[gi] = pipe_q[gi-1];
  end

  always_comb begin
    valid_d    = pipe_q[READ_LATENCY-1];
    triangle_d = pipe_q[READ_LATENCY-1] ? tri_data : triangle_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q     <= '0;
      issued_q   <= '0;
      issue_q    <= 1'b0;
      pipe_q     <= '0;
      triangle_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      issued_q   <= issued_d;
      issue_q    <= issue_d;
      pipe_q     <= pipe_d;
      triangle_q <= triangle_d;
      valid_q    <= valid_d;
    end
  end

  assign addr     = addr_q;
  assign triangle = triangle_q;
  assign valid    = valid_q;
  assign drained  = !issue_q && ((pipe_q & READ_LATENCY'(LOWER_MASK_I)) == '0);

endmodule

// File: rtl/render_scheduler.sv
// Render scheduler: once per frame tick, resets the renderer, streams up to
// MAX_TRIANGLES triangles from the triangle RAM into it, then enables
// rasterisation until the renderer reports completion.
// Optional feature macro: RENDER_WATCHDOG_EN adds a RENDERING timeout of
// WATCHDOG_CYCLES cycles with a sticky timeout flag.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   enable, frame_tick            : frame start gating and pacing pulse
//   tri_count                     : triangles this frame (sampled at frame start)
//   tri_addr / tri_data           : triangle RAM read port
//   render_rst                    : one-cycle renderer reset
//   render_triangle(_valid)       : triangle stream to the renderer
//   render_active / render_done   : rasterise enable and completion
//   busy, frame_count, dropped_ticks, timeout : status for the debug display
module render_scheduler
  import render_pkg::*;
#(
  parameter int TRI_WIDTH       = 128,
  parameter int MAX_TRIANGLES   = 64,
  parameter int READ_LATENCY    = 2,
  parameter int WATCHDOG_CYCLES = 4000000,
  localparam int CNT_W  = $clog2(MAX_TRIANGLES + 1),
  localparam int ADDR_W = $clog2(MAX_TRIANGLES)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 frame_tick,
  input  logic [CNT_W-1:0]     tri_count,
  output logic [ADDR_W-1:0]    tri_addr,
  input  logic [TRI_WIDTH-1:0] tri_data,
  output logic                 render_rst,
  output logic [TRI_WIDTH-1:0] render_triangle,
  output logic                 render_triangle_valid,
  output logic                 render_active,
  input  logic                 render_done,
  output logic                 busy,
  output logic [15:0]          frame_count,
  output logic [15:0]          dropped_ticks,
  output logic                 timeout
);

  if (WATCHDOG_CYCLES < 1) begin : g_bad_watchdog
    $error("WATCHDOG_CYCLES must be at least 1");
  end

  sched_state_t     state_q, state_d;
  logic [CNT_W-1:0] n_q, n_d;
  logic             pending_q, pending_d;
  logic             render_rst_q, render_rst_d;
  logic             render_active_q, render_active_d;
  logic             busy_q, busy_d;
  logic [15:0]      frame_count_q, frame_count_d;
  logic [15:0]      dropped_q, dropped_d;
  logic             leave_idle;
  logic             fetch_start;
  logic             fetch_drained;

`ifdef RENDER_WATCHDOG_EN
  localparam int WD_W = (WATCHDOG_CYCLES > 1) ? $clog2(WATCHDOG_CYCLES) : 1;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            timeout_q, timeout_d;
`endif

  always_comb begin
    state_d         = state_q;
    n_d             = n_q;
    render_rst_d    = 1'b0;
    render_active_d = render_active_q;
    frame_count_d   = frame_count_q;
    leave_idle      = 1'b0;
    fetch_start     = 1'b0;
`ifdef RENDER_WATCHDOG_EN
    wd_d      = wd_q;
    timeout_d = timeout_q;
`endif
    case (state_q)
      IDLE: begin
        if (pending_q && enable) begin
          n_d          = (tri_count > CNT_W'(MAX_TRIANGLES)) ? CNT_W'(MAX_TRIANGLES) : tri_count;
          render_rst_d = 1'b1;
          leave_idle   = 1'b1;
          state_d      = RRST;
        end
      end
      RRST: begin
        if (n_q == '0) begin
          state_d = START;
        end else begin
          fetch_start = 1'b1;
          state_d     = LOAD;
        end
      end
      LOAD: begin
        // Leaving as the last word is captured makes render_active rise one
        // cycle after the final valid.
        if (fetch_drained) begin
          state_d = START;
        end
      end
      START: begin
        render_active_d = 1'b1;
        state_d         = RENDERING;
`ifdef RENDER_WATCHDOG_EN
        wd_d = '0;
`endif
      end
      RENDERING: begin
        if (render_done) begin
          render_active_d = 1'b0;
          frame_count_d   = frame_count_q + 16'd1;
          state_d         = IDLE;
        end
`ifdef RENDER_WATCHDOG_EN
        else if (wd_q == WD_W'(WATCHDOG_CYCLES - 1)) begin
          render_active_d = 1'b0;
          timeout_d       = 1'b1;
          state_d         = IDLE;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // A tick arriving while one is already waiting is lost; a tick in the cycle
  // the waiting one is consumed simply becomes the next pending tick.
  always_comb begin
    pending_d = pending_q;
    dropped_d = dropped_q;
    if (leave_idle) begin
      pending_d = 1'b0;
    end
    if (frame_tick) begin
      pending_d = 1'b1;
      if (pending_q && !leave_idle && (dropped_q != 16'hFFFF)) begin
        dropped_d = dropped_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      n_q             <= '0;
      pending_q       <= 1'b0;
      render_rst_q    <= 1'b0;
      render_active_q <= 1'b0;
      busy_q          <= 1'b0;
      frame_count_q   <= '0;
      dropped_q       <= '0;
    end else begin
      state_q         <= state_d;
      n_q             <= n_d;
      pending_q       <= pending_d;
      render_rst_q    <= render_rst_d;
      render_active_q <= render_active_d;
      busy_q          <= busy_d;
      frame_count_q   <= frame_count_d;
      dropped_q       <= dropped_d;
    end
  end

`ifdef RENDER_WATCHDOG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  tri_fetch_pipe #(
    .TRI_WIDTH     (TRI_WIDTH),
    .MAX_TRIANGLES (MAX_TRIANGLES),
    .READ_LATENCY  (READ_LATENCY)
  ) u_fetch (
    .clk      (clk),
    .rst      (rst),
    .start    (fetch_start),
    .n        (n_q),
    .addr     (tri_addr),
    .tri_data (tri_data),
    .triangle (render_triangle),
    .valid    (render_triangle_valid),
    .drained  (fetch_drained)
  );

  assign render_rst    = render_rst_q;
  assign render_active = render_active_q;
  assign busy          = busy_q;
  assign frame_count   = frame_count_q;
  assign dropped_ticks = dropped_q;

endmodule

// File: tb/tb_render_scheduler.sv
module tb_render_scheduler;
  import render_pkg::*;

  localparam int MAXT = 64;
  localparam int CW   = 7;
  localparam int AW   = 6;

  logic            clk = 1'b0;
  logic            rst;
  logic            enable;
  logic            frame_tick;
  logic [CW-1:0]   tri_count;
  logic [AW-1:0]   tri_addr;
  triangle_t       tri_data;
  logic            render_rst;
  triangle_t       render_triangle;
  logic            render_triangle_valid;
  logic            render_active;
  logic            render_done;
  logic            busy;
  logic [15:0]     frame_count;
  logic [15:0]     dropped_ticks;
  logic            timeout;

  int checks   = 0;
  int failures = 0;

  triangle_t mem [MAXT];
  triangle_t rd_stage;
  triangle_t exp_q [$];
  triangle_t mon_exp;

  always #5 clk = ~clk;

  render_scheduler #(
    .TRI_WIDTH       (TRI_WIDTH),
    .MAX_TRIANGLES   (MAXT),
    .READ_LATENCY    (2),
    .WATCHDOG_CYCLES (100)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .enable                (enable),
    .frame_tick            (frame_tick),
    .tri_count             (tri_count),
    .tri_addr              (tri_addr),
    .tri_data              (tri_data),
    .render_rst            (render_rst),
    .render_triangle       (render_triangle),
    .render_triangle_valid (render_triangle_valid),
    .render_active         (render_active),
    .render_done           (render_done),
    .busy                  (busy),
    .frame_count           (frame_count),
    .dropped_ticks         (dropped_ticks),
    .timeout               (timeout)
  );

  // Triangle RAM with output register: two cycles from address to data.
  always @(posedge clk) begin
    rd_stage <= mem[tri_addr];
    tri_data <= rd_stage;
  end

  function automatic triangle_t tri_word(int i);
    return {32'hA000_0000 | 32'(i), 32'h0B00_0000 + 32'(i * 3), ~32'(i), 32'h1234_5678 ^ 32'(i)};
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0d required=%0d", name, act, exp);
    end else begin
      $display("ok   %s = %0d", name, act);
    end
  endtask

  // Monitor: every valid triangle is compared against the next expected word.
  always @(negedge clk) begin
    if (!rst && render_triangle_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL tri_unexpected got=%h required=none", render_triangle);
      end else begin
        mon_exp = exp_q.pop_front();
        if (render_triangle !== mon_exp) begin
          failures++;
          $display("FAIL tri_data got=%h required=%h", render_triangle, mon_exp);
        end else begin
          $display("txn  triangle %h", render_triangle);
        end
      end
    end
  end

  task automatic pulse_tick();
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic wait_rrst(output bit seen);
    seen = 1'b0;
    for (int w = 0; w < 50; w++) begin
      @(negedge clk);
      if (render_rst) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  // Follows one frame from the renderer reset to render_active rising.
  task automatic observe_load(int tc, string tag);
    int n;
    int first_v;
    int last_v;
    int nv;
    int act_k;
    bit seen;
    n       = (tc > MAXT) ? MAXT : tc;
    first_v = -1;
    last_v  = -1;
    nv      = 0;
    act_k   = -1;
    for (int i = 0; i < n; i++) exp_q.push_back(mem[i]);
    wait_rrst(seen);
    check({tag, "_rrst_seen"}, 64'(seen), 64'd1);
    check({tag, "_busy"}, 64'(busy), 64'd1);
    for (int k = 1; k < 200; k++) begin
      @(negedge clk);
      if (k == 1) check({tag, "_rrst_width"}, 64'(render_rst), 64'd0);
      if (render_triangle_valid) begin
        if (first_v < 0) first_v = k;
        last_v = k;
        nv++;
      end
      if (render_active) begin
        act_k = k;
        break;
      end
    end
    check({tag, "_valid_count"}, 64'(nv), 64'(n));
    if (n > 0) begin
      check({tag, "_first_valid_cycle"}, 64'(first_v), 64'd4);
      check({tag, "_last_valid_cycle"}, 64'(last_v), 64'(n + 3));
    end
    check({tag, "_active_cycle"}, 64'(act_k), (n == 0) ? 64'd2 : 64'(n + 4));
    check({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  task automatic finish_frame(int exp_fc, string tag);
    render_done = 1'b1;
    @(negedge clk);
    render_done = 1'b0;
    check({tag, "_active_low"}, 64'(render_active), 64'd0);
    check({tag, "_frame_count"}, 64'(frame_count), 64'(exp_fc));
    check({tag, "_busy_low"}, 64'(busy), 64'd0);
  endtask

  initial begin
    bit seen;
    int nv;
    int cnt;
    for (int i = 0; i < MAXT; i++) mem[i] = tri_word(i);
    rst         = 1'b1;
    enable      = 1'b1;
    frame_tick  = 1'b0;
    render_done = 1'b0;
    tri_count   = '0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_tri_addr", 64'(tri_addr), 64'd0);
    check("rst_render_triangle", 64'(render_triangle == '0), 64'd1);
    check("rst_outputs", 64'({render_rst, render_triangle_valid, render_active, busy, timeout}), 64'd0);
    check("rst_frame_count", 64'(frame_count), 64'd0);
    check("rst_dropped", 64'(dropped_ticks), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1: three triangles
    tri_count = 7'd3;
    pulse_tick();
    observe_load(3, "t1");
    check("t1_addr_hold", 64'(tri_addr), 64'd2);
    finish_frame(1, "t1");
    check("t1_dropped", 64'(dropped_ticks), 64'd0);

    // 2: empty frame
    tri_count = 7'd0;
    pulse_tick();
    observe_load(0, "t2");
    finish_frame(2, "t2");

    // 3: clamp to MAX_TRIANGLES
    tri_count = 7'd100;
    pulse_tick();
    observe_load(100, "t3");
    check("t3_addr_hold", 64'(tri_addr), 64'd63);
    finish_frame(3, "t3");

    // 4: ticks during RENDERING, then enable gating
    tri_count = 7'd2;
    pulse_tick();
    observe_load(2, "t4a");
    repeat (3) pulse_tick();
    check("t4_dropped", 64'(dropped_ticks), 64'd2);
    finish_frame(4, "t4a");
    observe_load(2, "t4b");
    finish_frame(5, "t4b");
    check("t4_dropped_after", 64'(dropped_ticks), 64'd2);
    enable = 1'b0;
    pulse_tick();
    repeat (10) @(negedge clk);
    check("t4_disabled_idle", 64'(busy), 64'd0);
    enable = 1'b1;
    observe_load(2, "t4c");
    finish_frame(6, "t4c");

    // 6: watchdog (or indefinite wait when the feature is not built)
    tri_count = 7'd1;
    pulse_tick();
    observe_load(1, "t6");
`ifdef RENDER_WATCHDOG_EN
    cnt = 1;
    for (int w = 0; w < 300; w++) begin
      @(negedge clk);
      if (!render_active) break;
      cnt++;
    end
    check("t6_active_cycles", 64'(cnt), 64'd100);
    check("t6_timeout", 64'(timeout), 64'd1);
    check("t6_frame_count", 64'(frame_count), 64'd6);
    check("t6_busy", 64'(busy), 64'd0);
    pulse_tick();
    observe_load(1, "t6b");
    finish_frame(7, "t6b");
    check("t6_timeout_sticky", 64'(timeout), 64'd1);
`else
    repeat (150) @(negedge clk);
    check("t6_active_held", 64'(render_active), 64'd1);
    check("t6_timeout_tied", 64'(timeout), 64'd0);
    finish_frame(7, "t6");
`endif

    // 5: reset in the middle of LOAD after two of five triangles
    tri_count = 7'd5;
    pulse_tick();
    for (int i = 0; i < 5; i++) exp_q.push_back(mem[i]);
    wait_rrst(seen);
    check("t5_rrst_seen", 64'(seen), 64'd1);
    nv = 0;
    for (int w = 0; w < 20; w++) begin
      @(negedge clk);
      if (render_triangle_valid) nv++;
      if (nv == 2) break;
    end
    check("t5_two_valids", 64'(nv), 64'd2);
    rst = 1'b1;
    @(negedge clk);
    exp_q.delete();
    check("t5_tri_addr", 64'(tri_addr), 64'd0);
    check("t5_render_triangle", 64'(render_triangle == '0), 64'd1);
    check("t5_outputs", 64'({render_rst, render_triangle_valid, render_active, busy, timeout}), 64'd0);
    check("t5_counters", 64'({frame_count, dropped_ticks}), 64'd0);
    rst = 1'b0;
    nv  = 0;
    for (int w = 0; w < 15; w++) begin
      @(negedge clk);
      if (render_triangle_valid) nv++;
    end
    check("t5_no_more_valids", 64'(nv), 64'd0);
    check("t5_idle", 64'(busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
